// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default widths.
package serial_sub_pkg;

   localparam int DEFAULT_N  = 8;
   localparam int DEFAULT_CW = 4;

   // Encoding 2'd3 is unused and recovers to ST_IDLE in the next-state logic.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_sub_full_sub1bit.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bi, bo = borrow out.
module full_sub1bit (
   output logic d,
   output logic bo,
   input  logic x,
   input  logic y,
   input  logic bi
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor, LSB first, one full-subtractor cell with a registered borrow.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int N  = DEFAULT_N,
   parameter int CW = DEFAULT_CW
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] diff,
   output logic         bout
);

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] cnt;
   logic [N-1:0]  a_sh;
   logic [N-1:0]  b_sh;
   logic [N-1:0]  r_sh;
   logic          borrow;
   logic          cell_d;
   logic          cell_bo;
   logic          last_bit;
   logic          accept;

   full_sub1bit u_cell (
      .d  (cell_d),
      .bo (cell_bo),
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .bi (borrow)
   );

   assign last_bit = (cnt == CW'(N - 1));
   assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_RUN;
         ST_RUN:  if (last_bit) state_next = ST_DONE;
         ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         ST_RUN:  busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // The final bit is written straight into diff so the result appears on the edge entering DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         r_sh   <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         r_sh   <= '0;
         borrow <= bin;
         cnt    <= '0;
      end else if (state == ST_RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         r_sh   <= {cell_d, r_sh[N-1:1]};
         borrow <= cell_bo;
         cnt    <= cnt + CW'(1);
         if (last_bit) begin
            diff <= {cell_d, r_sh[N-1:1]};
            bout <= cell_bo;
         end
      end
   end

endmodule
